// File: rtl/fft_r2_stage_pipe.sv
// fft_r2_stage_pipe: one pipelined radix-2 DIT butterfly stage of an
// N_POINTS-point fixed-point FFT. A whole parallel frame of N complex samples
// is taken per transfer and N/2 butterflies run side by side.
//
// Ports
//   clk, reset           rising-edge clock, synchronous active-high reset
//   in_valid/in_ready    input frame handshake (in_ready = global advance)
//   in_real/in_imag      N samples, sample i at [i*DW +: DW]
//   tw_real/tw_imag      N/2 twiddles Q(INTEGER.FRACTION), butterfly b at [b*DW +: DW]
//   scale                1 = halve butterfly outputs, captured with the frame
//   out_valid/out_ready  output frame handshake
//   out_real/out_imag    results, in-place ordering
//   ovf, ovf_clr         sticky saturation flag and its clear (set wins)

// Single butterfly lane: P1 forms the rounded/saturated product W*B and keeps
// A alongside it; P2 forms A +/- W*B with optional halving and saturation.
module fft_r2_bfly #(
    parameter int DW   = 8,
    parameter int FRAC = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ld1_i,     // P1 captures this cycle
    input  logic                 ld2_i,     // P2 captures this cycle
    input  logic                 scale_i,   // scale of the frame held in P1
    input  logic signed [DW-1:0] a_re_i,
    input  logic signed [DW-1:0] a_im_i,
    input  logic signed [DW-1:0] b_re_i,
    input  logic signed [DW-1:0] b_im_i,
    input  logic signed [DW-1:0] w_re_i,
    input  logic signed [DW-1:0] w_im_i,
    output logic signed [DW-1:0] p_re_o,
    output logic signed [DW-1:0] p_im_o,
    output logic signed [DW-1:0] q_re_o,
    output logic signed [DW-1:0] q_im_o,
    output logic                 clip1_o,   // product clips (unqualified)
    output logic                 clip2_o    // sum/diff clips (unqualified)
);
    localparam int MW = 2*DW;
    localparam int PW = 2*DW + 1;
    localparam int SW = DW + 2;
    localparam logic signed [PW-1:0] RND   = PW'(1 <<< (FRAC-1));
    localparam logic signed [PW-1:0] P_MAX = PW'((1 <<< DW) - 1);
    localparam logic signed [PW-1:0] P_MIN = -P_MAX - PW'(1);
    localparam logic signed [SW-1:0] O_MAX = SW'((1 <<< (DW-1)) - 1);
    localparam logic signed [SW-1:0] O_MIN = -O_MAX - SW'(1);

    // {clip, value} saturation to DW+1 bits
    function automatic logic [DW+1:0] sat_p(input logic signed [PW-1:0] x);
        if (x > P_MAX) return {1'b1, P_MAX[DW:0]};
        if (x < P_MIN) return {1'b1, P_MIN[DW:0]};
        return {1'b0, x[DW:0]};
    endfunction

    // {clip, value} saturation to DW bits
    function automatic logic [DW:0] sat_o(input logic signed [SW-1:0] x);
        if (x > O_MAX) return {1'b1, O_MAX[DW-1:0]};
        if (x < O_MIN) return {1'b1, O_MIN[DW-1:0]};
        return {1'b0, x[DW-1:0]};
    endfunction

    logic signed [MW-1:0] m_rr, m_ii, m_ri, m_ir;
    logic signed [PW-1:0] pr_w, pi_w;
    logic        [DW+1:0] pr_s, pi_s;
    logic signed [DW-1:0] a_re_q, a_im_q;
    logic signed [DW:0]   pr_q, pi_q;
    logic signed [SW-1:0] s_re, s_im, d_re, d_im;
    logic        [DW:0]   s_re_s, s_im_s, d_re_s, d_im_s;
    logic signed [DW-1:0] p_re_q, p_im_q, q_re_q, q_im_q;

    assign m_rr = MW'(w_re_i) * MW'(b_re_i);
    assign m_ii = MW'(w_im_i) * MW'(b_im_i);
    assign m_ri = MW'(w_re_i) * MW'(b_im_i);
    assign m_ir = MW'(w_im_i) * MW'(b_re_i);

    always_comb begin
        // round half-up at full precision, then drop the fraction bits
        pr_w    = (PW'(m_rr) - PW'(m_ii) + RND) >>> FRAC;
        pi_w    = (PW'(m_ri) + PW'(m_ir) + RND) >>> FRAC;
        pr_s    = sat_p(pr_w);
        pi_s    = sat_p(pi_w);
        clip1_o = pr_s[DW+1] | pi_s[DW+1];
    end

    always_comb begin
        s_re = SW'(a_re_q) + SW'(pr_q);
        s_im = SW'(a_im_q) + SW'(pi_q);
        d_re = SW'(a_re_q) - SW'(pr_q);
        d_im = SW'(a_im_q) - SW'(pi_q);
        if (scale_i) begin
            s_re = s_re >>> 1;
            s_im = s_im >>> 1;
            d_re = d_re >>> 1;
            d_im = d_im >>> 1;
        end
        s_re_s  = sat_o(s_re);
        s_im_s  = sat_o(s_im);
        d_re_s  = sat_o(d_re);
        d_im_s  = sat_o(d_im);
        clip2_o = s_re_s[DW] | s_im_s[DW] | d_re_s[DW] | d_im_s[DW];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_re_q <= '0;
            a_im_q <= '0;
            pr_q   <= '0;
            pi_q   <= '0;
            p_re_q <= '0;
            p_im_q <= '0;
            q_re_q <= '0;
            q_im_q <= '0;
        end else begin
            if (ld1_i) begin
                a_re_q <= a_re_i;
                a_im_q <= a_im_i;
                pr_q   <= pr_s[DW:0];
                pi_q   <= pi_s[DW:0];
            end
            if (ld2_i) begin
                p_re_q <= s_re_s[DW-1:0];
                p_im_q <= s_im_s[DW-1:0];
                q_re_q <= d_re_s[DW-1:0];
                q_im_q <= d_im_s[DW-1:0];
            end
        end
    end

    assign p_re_o = p_re_q;
    assign p_im_o = p_im_q;
    assign q_re_o = q_re_q;
    assign q_im_o = q_im_q;
endmodule

module fft_r2_stage_pipe #(
    parameter int DATA_WIDTH = 8,
    parameter int INTEGER    = 4,
    parameter int FRACTION   = 4,
    parameter int N_POINTS   = 32,
    parameter int STAGE      = 0
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [N_POINTS*DATA_WIDTH-1:0]      in_real,
    input  logic [N_POINTS*DATA_WIDTH-1:0]      in_imag,
    input  logic [(N_POINTS/2)*DATA_WIDTH-1:0]  tw_real,
    input  logic [(N_POINTS/2)*DATA_WIDTH-1:0]  tw_imag,
    input  logic                                scale,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [N_POINTS*DATA_WIDTH-1:0]      out_real,
    output logic [N_POINTS*DATA_WIDTH-1:0]      out_imag,
    output logic                                ovf,
    input  logic                                ovf_clr
);
    localparam int DW = DATA_WIDTH;
    localparam int NB = N_POINTS / 2;
    localparam int H  = N_POINTS >> (STAGE + 1);

    if (INTEGER + FRACTION != DATA_WIDTH) begin : g_fmt_err
        $error("INTEGER + FRACTION must equal DATA_WIDTH");
    end

    logic [1:0]    vld_pipe_q;   // [0]: P1 holds a frame, [1]: output holds a frame
    logic          scale_q;
    logic          ovf_q, ovf_d;
    logic          adv, ld1, ld2;
    logic [NB-1:0] clip1, clip2;

    // Whole pipe moves together; a stalled output freezes P1 as well.
    assign adv      = !vld_pipe_q[1] || out_ready;
    assign in_ready = adv;
    assign ld1      = adv && in_valid;
    assign ld2      = adv && vld_pipe_q[0];

    always_comb begin
        ovf_d = ovf_q;
        if (ovf_clr) ovf_d = 1'b0;
        if ((ld1 && |clip1) || (ld2 && |clip2)) ovf_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_pipe_q <= '0;
            scale_q    <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            if (adv) vld_pipe_q <= {vld_pipe_q[0], in_valid};
            if (ld1) scale_q <= scale;
        end
    end

    for (genvar b = 0; b < NB; b++) begin : g_bfly
        localparam int P = 2*(b/H)*H + (b%H);
        localparam int Q = P + H;
        fft_r2_bfly #(.DW(DW), .FRAC(FRACTION)) u_bfly (
            .clk     (clk),
            .reset   (reset),
            .ld1_i   (ld1),
            .ld2_i   (ld2),
            .scale_i (scale_q),
            .a_re_i  (in_real[P*DW +: DW]),
            .a_im_i  (in_imag[P*DW +: DW]),
            .b_re_i  (in_real[Q*DW +: DW]),
            .b_im_i  (in_imag[Q*DW +: DW]),
            .w_re_i  (tw_real[b*DW +: DW]),
            .w_im_i  (tw_imag[b*DW +: DW]),
            .p_re_o  (out_real[P*DW +: DW]),
            .p_im_o  (out_imag[P*DW +: DW]),
            .q_re_o  (out_real[Q*DW +: DW]),
            .q_im_o  (out_imag[Q*DW +: DW]),
            .clip1_o (clip1[b]),
            .clip2_o (clip2[b])
        );
    end

    assign out_valid = vld_pipe_q[1];
    assign ovf       = ovf_q;
endmodule

// File: tb/tb_fft_r2_stage_pipe.sv
// Bench for fft_r2_stage_pipe: a 32-point stage-0 instance (main DUT) and an
// 8-point stage-2 instance. Expected frames come from an integer model of the
// butterfly equations; a negedge monitor scores every delivered frame.
module tb_fft_r2_stage_pipe;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset;
    logic         a_iv, a_ir, a_sc, a_ov, a_or, a_ovf, a_clr;
    logic [255:0] a_xr, a_xi, a_yr, a_yi;
    logic [127:0] a_wr, a_wi;
    logic         b_iv, b_ir, b_sc, b_ov, b_ovf;
    logic [63:0]  b_xr, b_xi, b_yr, b_yi;
    logic [31:0]  b_wr, b_wi;

    int checks = 0, errors = 0, delivered = 0;
    logic [512:0] expq[$];

    fft_r2_stage_pipe #(.DATA_WIDTH(8), .INTEGER(4), .FRACTION(4), .N_POINTS(32), .STAGE(0)) u_a (
        .clk(clk), .reset(reset), .in_valid(a_iv), .in_ready(a_ir),
        .in_real(a_xr), .in_imag(a_xi), .tw_real(a_wr), .tw_imag(a_wi), .scale(a_sc),
        .out_valid(a_ov), .out_ready(a_or), .out_real(a_yr), .out_imag(a_yi),
        .ovf(a_ovf), .ovf_clr(a_clr));

    fft_r2_stage_pipe #(.DATA_WIDTH(8), .INTEGER(4), .FRACTION(4), .N_POINTS(8), .STAGE(2)) u_b (
        .clk(clk), .reset(reset), .in_valid(b_iv), .in_ready(b_ir),
        .in_real(b_xr), .in_imag(b_xi), .tw_real(b_wr), .tw_imag(b_wi), .scale(b_sc),
        .out_valid(b_ov), .out_ready(1'b1), .out_real(b_yr), .out_imag(b_yi),
        .ovf(b_ovf), .ovf_clr(1'b0));

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int clamp(input int v, input int lo, input int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    // Returns {any_clip, imag[255:0], real[255:0]} for an n-point frame.
    function automatic logic [512:0] model(input int n, input int st,
            input logic [255:0] xr, input logic [255:0] xi,
            input logic [127:0] wr, input logic [127:0] wi, input bit sc);
        logic [255:0] yr, yi;
        bit c;
        int h, p, q, ar, ai, br, bi, tr, ti, pr, pi, v[4];
        yr = '0; yi = '0; c = 0;
        h = n >> (st + 1);
        for (int b = 0; b < n/2; b++) begin
            p  = 2*(b/h)*h + (b%h);
            q  = p + h;
            ar = $signed(xr[p*8 +: 8]); ai = $signed(xi[p*8 +: 8]);
            br = $signed(xr[q*8 +: 8]); bi = $signed(xi[q*8 +: 8]);
            tr = $signed(wr[b*8 +: 8]); ti = $signed(wi[b*8 +: 8]);
            pr = (tr*br - ti*bi + 8) >>> 4;
            pi = (tr*bi + ti*br + 8) >>> 4;
            c |= (clamp(pr, -256, 255) != pr) || (clamp(pi, -256, 255) != pi);
            pr = clamp(pr, -256, 255);
            pi = clamp(pi, -256, 255);
            v[0] = ar + pr; v[1] = ai + pi; v[2] = ar - pr; v[3] = ai - pi;
            for (int j = 0; j < 4; j++) begin
                if (sc) v[j] = v[j] >>> 1;
                c |= (clamp(v[j], -128, 127) != v[j]);
                v[j] = clamp(v[j], -128, 127);
            end
            yr[p*8 +: 8] = 8'(v[0]); yi[p*8 +: 8] = 8'(v[1]);
            yr[q*8 +: 8] = 8'(v[2]); yi[q*8 +: 8] = 8'(v[3]);
        end
        return {c, yi, yr};
    endfunction

    // Scoreboard for the main DUT: expected frames queued on accept.
    always @(negedge clk) begin
        logic [512:0] e;
        if (reset) expq.delete();
        else begin
            if (a_ov && a_or) begin
                chk("frame_expected", 512'(expq.size() != 0), 512'(1));
                if (expq.size() != 0) begin
                    e = expq.pop_front();
                    chk("frame_real", a_yr, 512'(e[255:0]));
                    chk("frame_imag", a_yi, 512'(e[511:256]));
                    delivered++;
                end
            end
            if (a_iv && a_ir) expq.push_back(model(32, 0, a_xr, a_xi, a_wr, a_wi, a_sc));
        end
    end

    task automatic rnd_a(input int wlim);
        for (int i = 0; i < 32; i++) begin
            a_xr[i*8 +: 8] = 8'($urandom);
            a_xi[i*8 +: 8] = 8'($urandom);
        end
        for (int i = 0; i < 16; i++) begin
            a_wr[i*8 +: 8] = (wlim == 0) ? 8'($urandom) : 8'(int'($urandom_range(0, 2*wlim)) - wlim);
            a_wi[i*8 +: 8] = (wlim == 0) ? 8'($urandom) : 8'(int'($urandom_range(0, 2*wlim)) - wlim);
        end
    endtask

    task automatic send_a(input string tag);
        int n;
        @(posedge clk); #1 a_iv = 1'b1;
        @(negedge clk);
        n = 0;
        while (!a_ir && n < 20) begin @(negedge clk); n++; end
        chk({tag, "_accept"}, 512'(a_ir), 512'(1));
        @(posedge clk); #1 a_iv = 1'b0;
        n = 0;
        while (!a_ov && n < 10) begin @(negedge clk); n++; end
        chk({tag, "_latency"}, 512'(n), 512'(2));
    endtask

    task automatic send_b(input string tag);
        int n;
        @(posedge clk); #1 b_iv = 1'b1;
        @(negedge clk);
        chk({tag, "_accept"}, 512'(b_ir), 512'(1));
        @(posedge clk); #1 b_iv = 1'b0;
        n = 0;
        while (!b_ov && n < 10) begin @(negedge clk); n++; end
        chk({tag, "_latency"}, 512'(n), 512'(2));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [512:0] e;
        logic [255:0] fr[3], fi[3];
        logic [511:0] snap;
        int d0, n;

        // 1: reset with in_valid held high
        reset = 1'b1; a_iv = 1'b1; a_sc = 1'b0; a_or = 1'b1; a_clr = 1'b0;
        a_xr = '0; a_xi = '0; a_wr = '0; a_wi = '0;
        b_iv = 1'b0; b_sc = 1'b0; b_xr = '0; b_xi = '0; b_wr = '0; b_wi = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 512'(a_ov), 512'(0));
        chk("rst_out_real", a_yr, 512'(0));
        chk("rst_out_imag", a_yi, 512'(0));
        chk("rst_ovf", 512'(a_ovf), 512'(0));
        chk("rst_in_ready", 512'(a_ir), 512'(1));
        @(posedge clk); #1 reset = 1'b0; a_iv = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("post_rst_idle", 512'(a_ov), 512'(0));
        end
        chk("post_rst_ready", 512'(a_ir), 512'(1));

        // 2: unity twiddles, ramp input
        for (int i = 0; i < 32; i++) a_xr[i*8 +: 8] = 8'(i);
        a_wr = {16{8'h10}}; a_wi = '0;
        send_a("ramp");
        chk("ramp_out0", 512'(a_yr[7:0]), 512'(8'h10));
        chk("ramp_out15", 512'(a_yr[15*8 +: 8]), 512'(8'h2E));
        chk("ramp_upper", 512'(a_yr[255:128]), 512'({16{8'hF0}}));
        chk("ramp_imag", a_yi, 512'(0));
        chk("ramp_ovf", 512'(a_ovf), 512'(0));

        // 3: -j twiddle on the 8-point, last-stage instance
        b_wr = '0; b_wi = {4{8'hF0}};
        b_xr = {4{8'h10, 8'h00}}; b_xi = '0;
        send_b("negj");
        chk("negj_real", 512'(b_yr), 512'(0));
        chk("negj_imag", 512'(b_yi), 512'({4{8'h10, 8'hF0}}));
        chk("negj_ovf", 512'(b_ovf), 512'(0));
        for (int it = 0; it < 4; it++) begin
            for (int i = 0; i < 8; i++) begin
                b_xr[i*8 +: 8] = 8'($urandom); b_xi[i*8 +: 8] = 8'($urandom);
            end
            b_wr = $urandom; b_wi = $urandom; b_sc = 1'($urandom);
            e = model(8, 2, {192'b0, b_xr}, {192'b0, b_xi}, {96'b0, b_wr}, {96'b0, b_wi}, b_sc);
            send_b("b_rand");
            chk("b_rand_real", 512'(b_yr), 512'(e[63:0]));
            chk("b_rand_imag", 512'(b_yi), 512'(e[256 +: 64]));
        end

        // 4: saturation, scaling and the sticky flag
        a_xr = {32{8'h70}}; a_xi = '0; a_wr = {16{8'h10}}; a_wi = '0; a_sc = 1'b0;
        send_a("sat");
        chk("sat_p_real", 512'(a_yr[7:0]), 512'(8'h7F));
        chk("sat_q_real", 512'(a_yr[16*8 +: 8]), 512'(0));
        chk("sat_ovf_set", 512'(a_ovf), 512'(1));
        @(posedge clk); #1 a_clr = 1'b1;
        @(posedge clk); #1 a_clr = 1'b0;
        @(negedge clk);
        chk("ovf_cleared", 512'(a_ovf), 512'(0));
        a_sc = 1'b1;
        send_a("scaled");
        chk("scaled_p_real", 512'(a_yr[7:0]), 512'(8'h70));
        chk("scaled_q_real", 512'(a_yr[16*8 +: 8]), 512'(0));
        chk("scaled_no_ovf", 512'(a_ovf), 512'(0));
        a_sc = 1'b0;
        @(posedge clk); #1 a_clr = 1'b1;
        send_a("clr_vs_clip");
        chk("set_wins", 512'(a_ovf), 512'(1));
        a_clr = 1'b0;

        // random frames, one at a time, with flag cleared beforehand
        for (int it = 0; it < 8; it++) begin
            rnd_a((it % 2 == 1) ? 16 : 0);
            a_sc = 1'($urandom);
            e = model(32, 0, a_xr, a_xi, a_wr, a_wi, a_sc);
            @(posedge clk); #1 a_clr = 1'b1;
            @(posedge clk); #1 a_clr = 1'b0;
            send_a("rand");
            chk("rand_ovf", 512'(a_ovf), 512'(e[512]));
        end

        // 5: three back-to-back frames against a 5-cycle output stall
        rnd_a(16); a_sc = 1'b0;
        for (int j = 0; j < 3; j++) begin
            rnd_a(16);
            fr[j] = a_xr; fi[j] = a_xi;
        end
        @(posedge clk); #1;
        d0 = delivered; a_or = 1'b0;
        a_xr = fr[0]; a_xi = fi[0]; a_iv = 1'b1;
        @(negedge clk); chk("bb_ready0", 512'(a_ir), 512'(1));
        @(posedge clk); #1 a_xr = fr[1]; a_xi = fi[1];
        @(negedge clk); chk("bb_ready1", 512'(a_ir), 512'(1));
        @(posedge clk); #1 a_xr = fr[2]; a_xi = fi[2];
        @(negedge clk);
        chk("bb_first_valid", 512'(a_ov), 512'(1));
        snap = {a_yi, a_yr};
        for (int c = 0; c < 5; c++) begin
            if (c > 0) @(negedge clk);
            chk("stall_in_ready", 512'(a_ir), 512'(0));
            chk("stall_valid", 512'(a_ov), 512'(1));
            chk("stall_hold", {a_yi, a_yr}, snap);
        end
        @(posedge clk); #1 a_or = 1'b1;
        @(negedge clk);
        n = 0;
        while (!a_ir && n < 10) begin @(negedge clk); n++; end
        chk("bb_ready2", 512'(a_ir), 512'(1));
        @(posedge clk); #1 a_iv = 1'b0;
        n = 0;
        while ((expq.size() != 0 || a_ov) && n < 20) begin @(negedge clk); n++; end
        chk("bb_delivered", 512'(delivered - d0), 512'(3));

        // 6: reset with two frames in flight
        rnd_a(16); fr[0] = a_xr; fi[0] = a_xi;
        rnd_a(16);
        @(posedge clk); #1 a_xr = fr[0]; a_xi = fi[0]; a_iv = 1'b1;
        @(posedge clk); #1 a_xr = fr[1]; a_xi = fi[1];
        @(posedge clk); #1 reset = 1'b1; a_iv = 1'b0;
        d0 = delivered;
        @(posedge clk); #1;
        @(posedge clk); #1 reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("flush_no_valid", 512'(a_ov), 512'(0));
        end
        chk("flush_none_delivered", 512'(delivered - d0), 512'(0));
        rnd_a(16);
        send_a("after_flush");
        @(negedge clk);
        chk("after_flush_delivered", 512'(delivered - d0), 512'(1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
